// File: rtl/repsub_divider_if.sv
// repsub_divider_if: host-side operand/result bundle for the repeated-subtraction divider
interface repsub_divider_if #(parameter int WIDTH = 16) ();
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  modport master (output start, data_in, input quotient, remainder, busy, done, div_by_zero);
  modport slave  (input start, data_in, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/repsub_divider.sv
// repsub_divider: unsigned divider subtracting the divisor once per cycle until remainder < divisor
module repsub_divider #(parameter int WIDTH = 16) (
  input logic             clk,
  input logic             reset,
  repsub_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_B, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] r, d, q, r_n, d_n, q_n;
  logic             dz, dz_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      d     <= '0;
      q     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      r     <= r_n;
      d     <= d_n;
      q     <= q_n;
      dz    <= dz_n;
    end
  end
  always_comb begin
    state_n = state;
    r_n     = r;
    d_n     = d;
    q_n     = q;
    dz_n    = dz;
    case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = LOAD_B;
        r_n     = bus.data_in;
        q_n     = '0;
        dz_n    = 1'b0;
      end
      LOAD_B: begin
        d_n     = bus.data_in;
        state_n = RUN;
      end
      RUN: if (d == '0) begin
        state_n = DONE;
        dz_n    = 1'b1;
        q_n     = '1;
      end else if (r >= d) begin
        r_n = r - d;
        q_n = q + WIDTH'(1);
      end else begin
        state_n = DONE;
      end
    endcase
  end
  // Results are gated so the bus reads zero until an operation has finished.
  assign bus.done        = state == DONE;
  assign bus.busy        = state == LOAD_B || state == RUN;
  assign bus.quotient    = bus.done ? q : '0;
  assign bus.remainder   = bus.done ? r : '0;
  assign bus.div_by_zero = bus.done & dz;
endmodule

// File: tb/tb_repsub_divider.sv
// tb_repsub_divider: random and directed divisions checked against an arithmetic model every cycle
module tb_repsub_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  repsub_divider_if #(.WIDTH(16)) bus ();
  repsub_divider #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int          ph;
  int          cnt;
  logic [15:0] ma, m_q, m_r;
  logic        m_dz;
  wire         m_busy = ph == 1 || ph == 2;
  wire         m_done = ph == 3;
  // Model: dividend latched, then the divisor fixes the result and the remaining cycle count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph <= 0; cnt <= 0; ma <= '0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
    end else if (ph == 0 || ph == 3) begin
      if (bus.start) begin
        ma <= bus.data_in;
        ph <= 1;
      end
    end else if (ph == 1) begin
      ph <= 2;
      if (bus.data_in == 0) begin
        m_q <= 16'hFFFF; m_r <= ma; m_dz <= 1'b1; cnt <= 1;
      end else begin
        m_q <= ma / bus.data_in; m_r <= ma % bus.data_in; m_dz <= 1'b0; cnt <= int'(ma / bus.data_in) + 1;
      end
    end else begin
      cnt <= cnt - 1;
      if (cnt == 1) ph <= 3;
    end
  end
  always @(negedge clk) begin
    if (checking) begin
      total++;
      if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !==
          {m_busy, m_done, m_done ? m_q : 16'h0, m_done ? m_r : 16'h0, m_done & m_dz}) begin
        bad++;
        $display("FAIL cycle t=%0t busy/done/q/r/dz got=%b/%b/%h/%h/%b want=%b/%b/%h/%h/%b", $time,
                 bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                 m_busy, m_done, m_done ? m_q : 16'h0, m_done ? m_r : 16'h0, m_done & m_dz);
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  // Called at a negedge; the next posedge is E0. Returns at the negedge where done is first seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz,
                        input string nm, input bit noise);
    int n;
    bus.start = 1'b1;
    bus.data_in = a;
    @(negedge clk);
    chk({nm, " done_drop"}, 32'(bus.done), 0);
    bus.data_in = b;
    n = 0;
    while (n < lat + 20) begin
      bus.start = noise && (n == 0 || n == 1 || n == 4);
      if (noise && (n == 1 || n == 4)) bus.data_in = 16'd3;
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " quotient"}, 32'(bus.quotient), 32'(eq));
    chk({nm, " remainder"}, 32'(bus.remainder), 32'(er));
    chk({nm, " dz"}, 32'(bus.div_by_zero), 32'(edz));
    chk({nm, " model_q"}, 32'(m_q), 32'(eq));
  endtask
  initial begin
    logic [15:0] a, b, eq;
    bus.start = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset outputs", {bus.quotient, bus.remainder} | 32'(bus.div_by_zero), 0);
    reset = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    run_op(16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0, "basic", 1'b0);
    run_op(16'd5, 16'd9, 2, 16'd0, 16'd5, 1'b0, "small", 1'b0);
    run_op(16'd0, 16'd3, 2, 16'd0, 16'd0, 1'b0, "zero_dividend", 1'b0);
    run_op(16'd42, 16'd0, 2, 16'hFFFF, 16'd42, 1'b1, "div0", 1'b0);
    run_op(16'd10, 16'd2, 7, 16'd5, 16'd0, 1'b0, "after_div0", 1'b0);
    run_op(16'hFFFF, 16'd1, 65537, 16'hFFFF, 16'd0, 1'b0, "worst", 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 3, 16'd1, 16'd0, 1'b0, "equal", 1'b0);
    run_op(16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0, "ignored_start", 1'b1);
    run_op(16'd9, 16'd4, 4, 16'd2, 16'd1, 1'b0, "back_to_back", 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data_in = 16'd7;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort done", 32'(bus.done), 0);
    chk("abort outputs", {bus.quotient, bus.remainder} | 32'(bus.div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(16'd20, 16'd6, 5, 16'd3, 16'd2, 1'b0, "after_abort", 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 9) == 0) ? 16'd0 : (a >> 5) + 16'($urandom_range(1, 500));
      eq = (b == 0) ? 16'hFFFF : a / b;
      run_op(a, b, (b == 0) ? 2 : int'(eq) + 2, eq, (b == 0) ? a : a % b, b == 0, "random", i[0]);
    end
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
